// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel colour type and write-scheduler enums.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Shared by the VGA block, the CPU address decoder and fb_write_scheduler.
package fb_pkg;

  localparam int FB_WIDTH      = 40;   // framebuffer columns
  localparam int FB_HEIGHT     = 30;   // framebuffer rows
  localparam int FB_ADDR_WIDTH = 11;   // 2**11 >= 40*30
  localparam int FB_DATA_WIDTH = 3;    // RGB, one bit per channel
  localparam int FB_PIXELS     = FB_WIDTH * FB_HEIGHT;

  typedef logic [FB_DATA_WIDTH-1:0] fb_color_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_SETUP,
    FILL_RUN
  } fill_state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_FILL
  } grant_src_t;

endpackage

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle-fill engine; clips the box to the framebuffer and walks it row-major.
// Latency: start -> SETUP next cycle -> first request the cycle after; done registered one cycle after the last grant.
// Backpressure: req is held every RUN cycle; the cursor only advances when grant is high.
// Ports: clock/reset_n; start + x0/y0/w/h/color (sampled in IDLE only); req/addr/data/grant to the arbiter;
//        busy (state != IDLE), done (1-cycle pulse, also for an empty rectangle).
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [5:0]               x0,
  input  logic [4:0]               y0,
  input  logic [5:0]               w,
  input  logic [4:0]               h,
  input  logic [FB_DATA_WIDTH-1:0] color,
  output logic                     req,
  output logic [FB_ADDR_WIDTH-1:0] addr,
  output logic [FB_DATA_WIDTH-1:0] data,
  input  logic                     grant,
  output logic                     busy,
  output logic                     done
);

  fill_state_t               state_q, state_d;
  logic [5:0]                x0_q, w_q, x_q;
  logic [4:0]                y0_q, h_q, y_q;
  fb_color_t                 color_q;
  logic [6:0]                xe_q, ye_q;       // exclusive clipped bounds
  logic [FB_ADDR_WIDTH-1:0]  row_base_q;       // y_q * FB_WIDTH, kept incrementally

  logic [6:0] x_sum, y_sum, xe_clip, ye_clip;
  logic       empty, last_col, last_row, done_set;

  always_comb begin
    // 7-bit sums cannot overflow: 63+63 and 31+31 both fit.
    x_sum    = {1'b0, x0_q} + {1'b0, w_q};
    y_sum    = {2'b0, y0_q} + {2'b0, h_q};
    xe_clip  = (x_sum > 7'(FB_WIDTH))  ? 7'(FB_WIDTH)  : x_sum;
    ye_clip  = (y_sum > 7'(FB_HEIGHT)) ? 7'(FB_HEIGHT) : y_sum;
    empty    = (w_q == 6'd0) || (h_q == 5'd0) ||
               ({1'b0, x0_q} >= 7'(FB_WIDTH)) || ({2'b0, y0_q} >= 7'(FB_HEIGHT));
    last_col = ({1'b0, x_q} + 7'd1) == xe_q;
    last_row = ({2'b0, y_q} + 7'd1) == ye_q;

    state_d  = state_q;
    req      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (start) state_d = FILL_SETUP;
      end
      FILL_SETUP: begin
        if (empty) begin
          state_d  = FILL_IDLE;
          done_set = 1'b1;
        end else begin
          state_d  = FILL_RUN;
        end
      end
      FILL_RUN: begin
        req = 1'b1;
        if (grant && last_col && last_row) begin
          state_d  = FILL_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= FILL_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_set;
      case (state_q)
        FILL_IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= w;
            h_q     <= h;
            color_q <= color;
          end
        end
        FILL_SETUP: begin
          xe_q       <= xe_clip;
          ye_q       <= ye_clip;
          x_q        <= x0_q;
          y_q        <= y0_q;
          // One multiply per fill to seed the row base; the pixel loop only adds.
          row_base_q <= FB_ADDR_WIDTH'(y0_q) * FB_ADDR_WIDTH'(FB_WIDTH);
        end
        FILL_RUN: begin
          if (grant) begin
            if (last_col) begin
              x_q        <= x0_q;
              y_q        <= y_q + 5'd1;
              row_base_q <= row_base_q + FB_ADDR_WIDTH'(FB_WIDTH);
            end else begin
              x_q        <= x_q + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addr = row_base_q + FB_ADDR_WIDTH'(x_q);
  assign data = color_q;
  assign busy = (state_q != FILL_IDLE);

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: owns the framebuffer write port, round-robin between CPU stores and the fill engine.
// Latency: grant in cycle N -> fb_we/fb_addr/fb_data registered in N+1; cpu_ack is combinational in N.
// Backpressure: cpu_req is held until cpu_ack; fill stalls per pixel until granted.
// Ports: clock, reset_n (async, active-low); cpu_req/addr/data -> cpu_ack; fill_start + fill_x0/y0/w/h/color
//        -> fill_busy/fill_done; vblank; fb_we/fb_addr/fb_data to the VGA framebuffer write side.
// Build option FB_WR_VBLANK_ONLY_EN: grants only while vblank=1; otherwise vblank is ignored.
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cpu_req,
  input  logic [FB_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [FB_DATA_WIDTH-1:0] cpu_data,
  output logic                     cpu_ack,
  input  logic                     fill_start,
  input  logic [5:0]               fill_x0,
  input  logic [4:0]               fill_y0,
  input  logic [5:0]               fill_w,
  input  logic [4:0]               fill_h,
  input  logic [FB_DATA_WIDTH-1:0] fill_color,
  output logic                     fill_busy,
  output logic                     fill_done,
  input  logic                     vblank,
  output logic                     fb_we,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  output logic [FB_DATA_WIDTH-1:0] fb_data
);

  logic                     fill_req, grant_fill, grant_cpu;
  logic [FB_ADDR_WIDTH-1:0] fill_addr;
  logic [FB_DATA_WIDTH-1:0] fill_data;
  logic                     arb_en_q;     // keeps cpu_ack low while reset is asserted
  logic                     win_gate;
  logic                     cpu_elig, fill_elig, cpu_in_range;
  grant_src_t               last_grant_q;

  fb_rect_fill u_fill (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (fill_start),
    .x0      (fill_x0),
    .y0      (fill_y0),
    .w       (fill_w),
    .h       (fill_h),
    .color   (fill_color),
    .req     (fill_req),
    .addr    (fill_addr),
    .data    (fill_data),
    .grant   (grant_fill),
    .busy    (fill_busy),
    .done    (fill_done)
  );

`ifdef FB_WR_VBLANK_ONLY_EN
  assign win_gate = arb_en_q & vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign win_gate      = arb_en_q;
`endif

  always_comb begin
    cpu_elig     = cpu_req  & win_gate;
    fill_elig    = fill_req & win_gate;
    // On contention the requester that did not win last time goes first.
    grant_cpu    = cpu_elig  & (~fill_elig | (last_grant_q == GRANT_FILL));
    grant_fill   = fill_elig & ~grant_cpu;
    cpu_in_range = cpu_addr < FB_ADDR_WIDTH'(FB_PIXELS);
  end

  assign cpu_ack = grant_cpu;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arb_en_q     <= 1'b0;
      last_grant_q <= GRANT_FILL;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
    end else begin
      arb_en_q <= 1'b1;
      fb_we    <= 1'b0;
      if (grant_cpu) begin
        last_grant_q <= GRANT_CPU;
        // Out-of-range stores are acked but never reach the framebuffer.
        if (cpu_in_range) begin
          fb_we   <= 1'b1;
          fb_addr <= cpu_addr;
          fb_data <= cpu_data;
        end
      end else if (grant_fill) begin
        last_grant_q <= GRANT_FILL;
        fb_we        <= 1'b1;
        fb_addr      <= fill_addr;
        fb_data      <= fill_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench for fb_write_scheduler (default build, vblank ignored).
// Latency: checks CPU writes land exactly one cycle after cpu_ack; fill writes in row-major order.
// Backpressure: exercises CPU/fill contention and the fill stalling while the CPU is served.
module tb_fb_write_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic [2:0]  cpu_data;
  logic        cpu_ack;
  logic        fill_start;
  logic [5:0]  fill_x0;
  logic [4:0]  fill_y0;
  logic [5:0]  fill_w;
  logic [4:0]  fill_h;
  logic [2:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        vblank;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [2:0]  fb_data;

  fb_write_scheduler dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vblank     (vblank),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    int due;   // cycle in which the write must appear (CPU entries only)
  } wr_t;

  wr_t cpu_q[$];
  wr_t fill_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int fill_wr_cnt = 0;
  int fill_first = 0;
  int fill_last = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Write-port monitor: CPU writes are identified by their exact due cycle,
  // everything else must be the next pixel of the running fill.
  always @(negedge clock) begin
    wr_t e;
    if (fb_we) begin
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        e = cpu_q.pop_front();
        check("cpu_wr_addr", fb_addr, e.addr);
        check("cpu_wr_data", fb_data, e.data);
      end else if (fill_q.size() > 0) begin
        e = fill_q.pop_front();
        check("fill_wr_addr", fb_addr, e.addr);
        check("fill_wr_data", fb_data, e.data);
        if (fill_wr_cnt == 0) fill_first = cyc;
        fill_last = cyc;
        fill_wr_cnt++;
      end else begin
        check("fb_we_unexpected", fb_we, 0);
      end
    end
    if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
      e = cpu_q.pop_front();
      check("cpu_wr_missing", 0, 1);
    end
    if (fill_done) done_cnt++;
  end

  // Raise a CPU store, wait for its ack, expect the write one cycle later.
  task automatic cpu_write(input int a, input int d, input bit expect_wr, output int lat);
    int  n;
    bit  got;
    wr_t e;
    n = 0;
    got = 0;
    cpu_addr = 11'(a);
    cpu_data = 3'(d);
    cpu_req  = 1'b1;
    while (!got && n < 20) begin
      @(negedge clock); #1;
      if (cpu_ack) got = 1;
      else n++;
    end
    lat = n;
    if (!got) begin
      check("cpu_ack_timeout", 0, 1);
      cpu_req = 1'b0;
    end else begin
      if (expect_wr) begin
        e.addr = a; e.data = d; e.due = cyc + 1;
        cpu_q.push_back(e);
      end
      @(posedge clock); #1;
      cpu_req = 1'b0;
      if (!expect_wr) begin
        @(negedge clock); #1;
        check("cpu_drop_we", fb_we, 0);
      end
    end
    @(posedge clock); #1;
  endtask

  // Start a fill, predict its clipped pixels, and check the done pulse.
  task automatic do_fill(input int x0, input int y0, input int w, input int h,
                         input int c, input bit contig);
    int  n;
    int  to;
    int  d0;
    wr_t e;
    n = 0;
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < 40 && y < 30) begin
          e.addr = y * 40 + x; e.data = c; e.due = 0;
          fill_q.push_back(e);
          n++;
        end
    fill_wr_cnt = 0;
    d0 = done_cnt;
    fill_x0 = 6'(x0); fill_y0 = 5'(y0); fill_w = 6'(w); fill_h = 5'(h); fill_color = 3'(c);
    fill_start = 1'b1;
    @(posedge clock); #1;
    fill_start = 1'b0;
    check("fill_busy_after_start", fill_busy, 1);
    to = 0;
    while (done_cnt == d0 && to < 300) begin
      @(negedge clock); #1;
      to++;
    end
    if (done_cnt == d0) begin
      check("fill_done_timeout", 0, 1);
    end else begin
      check("fill_we_at_done", fb_we, (n > 0));
      check("fill_busy_at_done", fill_busy, 0);
      check("fill_wr_count", fill_wr_cnt, n);
      check("fill_q_left", fill_q.size(), 0);
      if (contig && n > 0) check("fill_contiguous", fill_last - fill_first + 1, n);
    end
    fill_q.delete();
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  d0;
    int  to;
    wr_t e;

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    vblank = 1'b1;

    // Reset with random inputs: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      cpu_req    = 1'($urandom_range(0, 1));
      cpu_addr   = 11'($urandom);
      cpu_data   = 3'($urandom);
      fill_start = 1'($urandom_range(0, 1));
      fill_x0    = 6'($urandom);
      fill_y0    = 5'($urandom);
      fill_w     = 6'($urandom);
      fill_h     = 5'($urandom);
      fill_color = 3'($urandom);
      vblank     = 1'($urandom_range(0, 1));
      @(negedge clock); #1;
      check("reset_outputs", {cpu_ack, fill_busy, fill_done, fb_we, fb_addr, fb_data}, 0);
    end
    @(posedge clock); #1;
    cpu_req = 1'b0; fill_start = 1'b0; vblank = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      check("idle_no_we", fb_we, 0);
    end
    @(posedge clock); #1;

    // Single CPU store, then a few random ones.
    cpu_write(5, 3'b101, 1, lat);
    check("cpu_ack_immediate", lat, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_write($urandom_range(0, 1199), $urandom_range(0, 7), 1, lat);
    end

    // Plain fill: 42,43,44,82,83,84 back to back.
    do_fill(2, 1, 3, 2, 4, 1);

    // CPU store arriving mid-fill.
    fork
      do_fill(2, 1, 3, 2, 4, 0);
      begin
        repeat (3) @(posedge clock);
        #1;
        cpu_write(100, 2, 1, lat);
        check("contention_ack_within_2", (lat <= 2), 1);
      end
    join

    // Clipping and empty rectangles, out-of-range CPU store.
    do_fill(38, 29, 5, 4, 1, 1);
    do_fill(5, 5, 0, 3, 7, 0);
    do_fill(45, 0, 3, 3, 2, 0);
    cpu_write(1200, 6, 0, lat);

    // Reset in the middle of a fill.
    d0 = done_cnt;
    for (int x = 0; x < 10; x++) begin
      e.addr = 80 + x; e.data = 6; e.due = 0;
      fill_q.push_back(e);
    end
    fill_wr_cnt = 0;
    fill_x0 = 6'd0; fill_y0 = 5'd2; fill_w = 6'd10; fill_h = 5'd1; fill_color = 3'd6;
    fill_start = 1'b1;
    @(posedge clock); #1;
    fill_start = 1'b0;
    to = 0;
    while (fill_wr_cnt < 2 && to < 50) begin
      @(negedge clock); #1;
      to++;
    end
    check("abort_second_write_seen", fill_wr_cnt, 2);
    reset_n = 1'b0;
    #1;
    check("abort_we", fb_we, 0);
    check("abort_busy", fill_busy, 0);
    check("abort_done", fill_done, 0);
    fill_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_no_done_pulse", done_cnt - d0, 0);
    check("abort_busy_after", fill_busy, 0);
    cpu_write(300, 3, 1, lat);

    repeat (4) @(posedge clock);
    #1;
    check("cpu_q_drained", cpu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
